// File: rtl/cycle_sequencer_pkg.sv
// Shared encodings for the instruction-cycle sequencer: FSM states, opcode classes, beat phases.
package cycle_sequencer_pkg;

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [1:0] CLS_ALU   = 2'b00;
    localparam logic [1:0] CLS_LOAD  = 2'b01;
    localparam logic [1:0] CLS_STORE = 2'b10;
    localparam logic [1:0] CLS_JMP   = 2'b11;

    localparam logic [1:0] PH_T1 = 2'd0;
    localparam logic [1:0] PH_T2 = 2'd1;
    localparam logic [1:0] PH_T3 = 2'd2;
    localparam logic [1:0] PH_T4 = 2'd3;

    localparam logic [7:0] HALT_OP_DEF = 8'hFF;

endpackage

// File: rtl/cycle_sequencer_phase_checker.sv
// Tracks the t1..t4 rotation: locks on the first lone t1, then flags any beat that is not the expected one-hot.
module cycle_sequencer_phase_checker
    import cycle_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       t1,
    input  logic       t2,
    input  logic       t3,
    input  logic       t4,
    output logic       locked,
    output logic       beat_ok,
    output logic [1:0] phase
);

    logic [3:0] tv;
    logic [3:0] exp_vec;
    logic [1:0] exp_ph;

    assign tv      = {t1, t2, t3, t4};
    assign exp_vec = 4'b1000 >> exp_ph;

    // Before lock only a lone t1 counts as a beat; anything else is ignored while waiting.
    always_comb begin
        if (locked) begin
            beat_ok = (tv == exp_vec);
            phase   = exp_ph;
        end else begin
            beat_ok = (tv == 4'b1000);
            phase   = PH_T1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked <= 1'b0;
            exp_ph <= PH_T1;
        end else if (beat_ok) begin
            locked <= 1'b1;
            exp_ph <= phase + 2'd1;
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// CISC instruction-cycle sequencer: FETCH/DECODE/EXEC stepped by the t1..t4 beat,
// phase-decoded datapath strobes, HALT detection and sticky beat-error freeze.
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int             OPW     = 8,
    parameter logic [OPW-1:0] HALT_OP = HALT_OP_DEF,
    parameter int             CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t1,
    input  logic             t2,
    input  logic             t3,
    input  logic             t4,
    input  logic [OPW-1:0]   ir,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             alu_en,
    output logic             reg_wr,
    output logic             halted,
    output logic             phase_err,
    output logic [CNT_W-1:0] retired
);

    state_t     state;
    state_t     eff;
    logic [1:0] cls;
    logic       locked;
    logic       beat_ok;
    logic [1:0] phase;
    logic       viol;
    logic       at_t4;

    cycle_sequencer_phase_checker u_chk (
        .clk     (clk),
        .reset   (reset),
        .t1      (t1),
        .t2      (t2),
        .t3      (t3),
        .t4      (t4),
        .locked  (locked),
        .beat_ok (beat_ok),
        .phase   (phase)
    );

    assign viol  = locked & ~beat_ok;
    assign at_t4 = beat_ok & (phase == PH_T4);
    // The lock beat already behaves as FETCH t1 so the first mem_rd is not lost.
    assign eff   = (state == SYNC && beat_ok) ? FETCH : state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SYNC;
            cls       <= CLS_ALU;
            halted    <= 1'b0;
            phase_err <= 1'b0;
            retired   <= '0;
        end else if (viol) begin
            state     <= ERR;
            phase_err <= 1'b1;
        end else begin
            case (state)
                SYNC:   if (beat_ok) state <= FETCH;
                FETCH:  if (at_t4) state <= DECODE;
                DECODE: if (at_t4) begin
                    cls <= ir[OPW-1:OPW-2];
                    if (ir == HALT_OP) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        retired <= retired + CNT_W'(1);
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC:   if (at_t4) begin
                    retired <= retired + CNT_W'(1);
                    state   <= FETCH;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        alu_en  = 1'b0;
        reg_wr  = 1'b0;
        if (beat_ok && !reset) begin
            case (eff)
                FETCH: begin
                    mem_rd  = (phase == PH_T1);
                    ir_load = (phase == PH_T3);
                    pc_inc  = (phase == PH_T4);
                end
                EXEC: begin
                    case (cls)
                        CLS_ALU: begin
                            alu_en = (phase == PH_T2);
                            reg_wr = (phase == PH_T3);
                        end
                        CLS_LOAD: begin
                            mem_rd = (phase == PH_T1);
                            reg_wr = (phase == PH_T3);
                        end
                        CLS_STORE: mem_wr  = (phase == PH_T2);
                        default:   pc_load = (phase == PH_T4);
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
